serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor with borrow-in and borrow-out: diff = a - b - bin.
- Processes one bit per clock, LSB first, through a single full-subtractor cell. Trades latency for area.
- Sits behind any control unit that needs multi-bit subtraction without a wide ripple chain.
- Uses a start/busy/done handshake; the result is held stable until the next completion.

Parameters:
- WIDTH, 8, operand and result width in bits (legal: 2..32).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- bin  input  1  borrow-in, captured on accepted start
- busy  output  1  high while the operation is in progress
- done  output  1  single-cycle completion pulse
- diff  output  WIDTH  registered difference, valid from done onward
- bout  output  1  registered borrow-out, valid from done onward

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
- rst_n low forces state=IDLE, busy=0, done=0, diff=0, bout=0, and clears the counter, shift registers and borrow register.
- Reset mid-operation aborts the operation. diff/bout return to 0 and no done pulse occurs.
- IDLE state:
  - busy=0.
  - On start=1, latch a->a_sh, b->b_sh, bin->brw; counter=0; go to RUN.
- RUN state:
  - busy=1.
  - Each edge: d = a_sh[0]^b_sh[0]^brw; brw <= (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&brw).
  - d shifts into d_sh at the MSB; a_sh and b_sh shift right; counter increments.
  - When counter reaches WIDTH-1 on the current edge, go to FIN.
- FIN state:
  - diff <= d_sh (completed value) and bout <= brw, both registered on the FIN entry edge.
  - done=1 for exactly this one cycle; busy=0.
  - Next state is IDLE, or RUN directly if start=1 in this cycle (back-to-back start allowed).
- Latency: start accepted at edge k -> done high during the cycle after edge k+WIDTH.
  - Throughput is one result per WIDTH+1 cycles with back-to-back starts.
- start while in RUN is ignored; no queuing and no error flag.
- diff/bout change only on completion. They hold their value through IDLE and the next RUN.
- Arithmetic is modulo 2^WIDTH. bout=1 iff a < b + bin (unsigned).
- State encoding: IDLE=2'b00, RUN=2'b01, FIN=2'b10. 2'b11 recovers to IDLE.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined: extra output port ovf (1 bit, reset 0), updated alongside diff.
  - ovf = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), i.e. two's-complement signed overflow.
  - The operand MSBs are retained in a register at capture.
- Undefined: no ovf port and no MSB-capture register. Behaviour is otherwise identical.

Decomposition:
- Package serial_sub_pkg holds:
  - state encoding constants IDLE/RUN/FIN;
  - the WIDTH legal-range check constants.
- Sub-module full_subtractor_bit (inputs x, y, bi; outputs d, bo) is purely combinational.
  - Instantiated once in the datapath.
  - Reused by the bench as a golden bit model.

Test Plan:
- WIDTH=8: a=0x05, b=0x03, bin=0 -> done after 9 cycles; diff=0x02, bout=0.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- OVF_EN: a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1. a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- start pulsed mid-RUN with different operands -> ignored; first result unchanged; single done pulse.
- rst_n low at cycle 4 of RUN -> all outputs 0 immediately (asynchronous). The next start completes normally.
- Back-to-back: start held high through FIN -> second operation begins with no IDLE cycle.
  - Prior diff holds until the second done.
  - All 8 single-bit (a, b, bin) combinations at WIDTH=2 match full_subtractor_bit.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the legal operand-width range.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_e;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/full_subtractor_bit.sv
// Single-bit full subtractor: d = x - y - bi, with borrow-out bo.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor (diff = a - b - bin), one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add a signed-overflow output (ovf).
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("serial_subtractor: WIDTH out of legal range");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   dsh_q, dsh_d, diff_q, diff_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               brw_q, brw_d, bout_q, bout_d;
  logic               bit_d, bit_bo;
  logic               accept, finish;

  full_subtractor_bit u_cell (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (brw_q),
    .d  (bit_d),
    .bo (bit_bo)
  );

  // FIN accepts a new start just like IDLE, giving back-to-back operation.
  assign accept = start && (state_q == IDLE || state_q == FIN);
  assign finish = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    dsh_d   = dsh_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE, FIN: begin
        done    = (state_q == FIN);
        state_d = IDLE;
        if (accept) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        brw_d = bit_bo;
        dsh_d = {bit_d, dsh_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (finish) begin
          state_d = FIN;
          diff_d  = {bit_d, dsh_q[WIDTH-1:1]};
          bout_d  = bit_bo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      dsh_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      dsh_q   <= dsh_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are shifted out during RUN, so keep a copy for the check.
  logic a_msb_q, b_msb_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= b[WIDTH-1];
      end
      if (finish) begin
        ovf_q <= (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
      end
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
